// File: rtl/mips_dmem_responder.sv
// MEM-stage data target: combinational loads, stores committed on the rising edge,
// plus a peripheral window with timer/compare/IRQ, LED register and sticky bus-error status.
module mips_dmem_responder #(
  parameter int unsigned RAM_WORDS   = 64,
  parameter logic [31:0] PERIPH_BASE = 32'hFFFF0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] memaddr,
  input  logic [31:0] memwritedata,
  output logic [31:0] memreaddata,
  output logic [7:0]  leds,
  output logic        timer_irq,
  output logic        bus_err
);

  localparam int unsigned AW = $clog2(RAM_WORDS);

  localparam logic [3:0] OFF_CNT  = 4'h0;
  localparam logic [3:0] OFF_CMP  = 4'h1;
  localparam logic [3:0] OFF_CTRL = 4'h2;
  localparam logic [3:0] OFF_STAT = 4'h3;
  localparam logic [3:0] OFF_LED  = 4'h4;
  localparam logic [3:0] OFF_ERR  = 4'h5;

  logic [31:0] ram_q [RAM_WORDS];

  logic [31:0] cnt_q, cnt_d;
  logic [31:0] cmp_q, cmp_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        match_q, match_d;
  logic [7:0]  led_q, led_d;
  logic [1:0]  err_q, err_d;
  logic        irq_q, berr_q;

  logic          ram_hit, periph_hit, aligned, st_ok;
  logic          ram_we, periph_we;
  logic [AW-1:0] word_idx;
  logic [3:0]    off;
  logic          timer_en, autoclr, match_now;

  assign ram_hit    = (memaddr[31:AW+2] == '0);
  assign periph_hit = (memaddr[31:6] == PERIPH_BASE[31:6]);
  assign aligned    = (memaddr[1:0] == 2'b00);
  assign word_idx   = memaddr[AW+1:2];
  assign off        = memaddr[5:2];
  assign st_ok      = memwrite & aligned;
  // RAM has no reset, so the write is gated here to drop stores made while reset is held.
  assign ram_we     = st_ok & ram_hit & reset;
  assign periph_we  = st_ok & ~ram_hit & periph_hit;

  assign timer_en  = ctrl_q[0];
  assign autoclr   = ctrl_q[1];
  assign match_now = timer_en & (cnt_q == cmp_q);

  always_comb begin
    memreaddata = '0;
    if (ram_hit) begin
      memreaddata = ram_q[word_idx];
    end else if (periph_hit) begin
      case (off)
        OFF_CNT:  memreaddata = cnt_q;
        OFF_CMP:  memreaddata = cmp_q;
        OFF_CTRL: memreaddata = {29'd0, ctrl_q};
        OFF_STAT: memreaddata = {31'd0, match_q};
        OFF_LED:  memreaddata = {24'd0, led_q};
        OFF_ERR:  memreaddata = {30'd0, err_q};
        default:  memreaddata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[word_idx] <= memwritedata;
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    cmp_d   = cmp_q;
    ctrl_d  = ctrl_q;
    led_d   = led_q;
    match_d = match_q;
    err_d   = err_q;

    if (periph_we && off == OFF_CNT) begin
      cnt_d = memwritedata;
    end else if (match_now && autoclr) begin
      cnt_d = '0;
    end else if (timer_en) begin
      cnt_d = cnt_q + 32'd1;
    end

    if (periph_we && off == OFF_CMP)  cmp_d  = memwritedata;
    if (periph_we && off == OFF_CTRL) ctrl_d = memwritedata[2:0];
    if (periph_we && off == OFF_LED)  led_d  = memwritedata[7:0];

    // Clears are applied first so a simultaneous new event keeps the bit set.
    if (periph_we && off == OFF_STAT && memwritedata[0]) match_d = 1'b0;
    if (match_now) match_d = 1'b1;

    if (periph_we && off == OFF_ERR) err_d = err_q & ~memwritedata[1:0];
    if (memwrite && !aligned) err_d[1] = 1'b1;
    if (st_ok && !ram_hit && !periph_hit) err_d[0] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      cmp_q   <= 32'hFFFF_FFFF;
      ctrl_q  <= '0;
      match_q <= 1'b0;
      led_q   <= '0;
      err_q   <= '0;
      irq_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
      ctrl_q  <= ctrl_d;
      match_q <= match_d;
      led_q   <= led_d;
      err_q   <= err_d;
      irq_q   <= match_d & ctrl_d[2];
      berr_q  <= |err_d;
    end
  end

  assign leds      = led_q;
  assign timer_irq = irq_q;
  assign bus_err   = berr_q;

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Randomized + directed bench for mips_dmem_responder with a behavioural memory-map model
// and a scoreboard queue drained by an independent negedge monitor.
module tb_mips_dmem_responder;

  localparam int unsigned RAM_WORDS = 64;
  localparam logic [31:0] PB        = 32'hFFFF0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] memaddr = '0;
  logic [31:0] memwritedata = '0;
  logic [31:0] memreaddata;
  logic [7:0]  leds;
  logic        timer_irq;
  logic        bus_err;

  mips_dmem_responder #(.RAM_WORDS(RAM_WORDS), .PERIPH_BASE(PB)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .memaddr(memaddr),
    .memwritedata(memwritedata), .memreaddata(memreaddata), .leds(leds),
    .timer_irq(timer_irq), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        chk_rd;
    logic [31:0] rd;
    logic [7:0]  leds;
    logic        irq;
    logic        berr;
    logic [31:0] addr;
  } exp_t;

  exp_t scb[$];
  int checks = 0;
  int errors = 0;

  // Reference state of the memory map.
  logic [31:0] m_ram [RAM_WORDS];
  bit          m_known [RAM_WORDS];
  logic [31:0] m_cnt, m_cmp;
  logic [2:0]  m_ctrl;
  logic        m_match;
  logic [7:0]  m_led;
  logic [1:0]  m_err;

  task automatic model_reset();
    m_cnt = 0; m_cmp = 32'hFFFF_FFFF; m_ctrl = 0; m_match = 0; m_led = 0; m_err = 0;
  endtask

  function automatic logic model_read(input logic [31:0] a, output logic [31:0] v);
    int unsigned w;
    v = 32'd0;
    if (a < RAM_WORDS * 4) begin
      w = a / 4;
      v = m_ram[w];
      return m_known[w];
    end
    if (a >= PB && a < PB + 64) begin
      case ((a - PB) / 4)
        0: v = m_cnt;
        1: v = m_cmp;
        2: v = 32'(m_ctrl);
        3: v = 32'(m_match);
        4: v = 32'(m_led);
        5: v = 32'(m_err);
        default: v = 32'd0;
      endcase
    end
    return 1'b1;
  endfunction

  task automatic model_edge(input logic we, input logic [31:0] a, input logic [31:0] wd);
    logic        hit;
    logic [31:0] ncnt;
    logic        stat_clr;
    logic [1:0]  e_clr, e_new;
    hit = m_ctrl[0] && (m_cnt == m_cmp);
    ncnt = m_cnt;
    stat_clr = 0; e_clr = 0; e_new = 0;
    if (m_ctrl[0]) ncnt = (hit && m_ctrl[1]) ? 32'd0 : m_cnt + 32'd1;
    if (we) begin
      if (a % 4 != 0) e_new[1] = 1'b1;
      else if (a < RAM_WORDS * 4) begin
        m_ram[a / 4] = wd;
        m_known[a / 4] = 1'b1;
      end else if (a >= PB && a < PB + 64) begin
        case ((a - PB) / 4)
          0: ncnt = wd;
          1: m_cmp = wd;
          2: m_ctrl = wd[2:0];
          3: stat_clr = wd[0];
          4: m_led = wd[7:0];
          5: e_clr = wd[1:0];
          default: ;
        endcase
      end else e_new[0] = 1'b1;
    end
    m_cnt = ncnt;
    m_match = hit | (m_match & ~stat_clr);
    m_err = e_new | (m_err & ~e_clr);
  endtask

  // One bus cycle: drive inputs just after the edge, queue the expected view of this cycle,
  // then advance the model through the coming edge.
  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic rst_n);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst_n; memwrite = we; memaddr = a; memwritedata = wd;
    if (!rst_n) model_reset();
    e.chk_rd = model_read(a, e.rd);
    e.leds = m_led;
    e.irq  = m_match & m_ctrl[2];
    e.berr = |m_err;
    e.addr = a;
    scb.push_back(e);
    if (rst_n) model_edge(we, a, wd);
  endtask

  task automatic rd(input logic [31:0] a);
    step(1'b0, a, $urandom, 1'b1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wd);
    step(1'b1, a, wd, 1'b1);
  endtask

  task automatic chk(input string name, input logic [31:0] addr,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s addr=%h got=%h expected=%h", name, addr, got, exp);
    end
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (scb.size() != 0) begin
      mon_e = scb.pop_front();
      if (mon_e.chk_rd) chk("memreaddata", mon_e.addr, memreaddata, mon_e.rd);
      chk("leds", mon_e.addr, 32'(leds), 32'(mon_e.leds));
      chk("timer_irq", mon_e.addr, 32'(timer_irq), 32'(mon_e.irq));
      chk("bus_err", mon_e.addr, 32'(bus_err), 32'(mon_e.berr));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog addr=0 got=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, wd;
    logic        we, rl;
    int          r;
    for (int i = 0; i < RAM_WORDS; i++) m_known[i] = 1'b0;
    model_reset();

    // Reset held, then released.
    step(1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b0, PB + 32'h8, 32'h0, 1'b0);
    rd(PB);

    for (int i = 0; i < RAM_WORDS; i++) wr(32'(i * 4), $urandom);

    // Same-cycle read returns the old word; next cycle the new one.
    wr(32'h10, 32'hDEADBEEF);
    rd(32'h10);
    rd(32'h13);

    // Auto-clearing timer with IRQ.
    wr(PB + 32'h4, 32'd3);
    wr(PB + 32'h8, 32'd7);
    for (int i = 0; i < 7; i++) rd(PB);
    rd(PB + 32'hC);
    wr(PB + 32'hC, 32'd1);
    rd(PB + 32'hC);
    rd(PB + 32'hC);

    // CPU store to CNT beats auto-clear on a match edge.
    for (int i = 0; i < 10 && m_cnt != m_cmp; i++) rd(PB);
    wr(PB, 32'd100);
    rd(PB);
    rd(PB);
    rd(PB + 32'hC);
    wr(PB + 32'h8, 32'd0);

    // Bus errors.
    wr(32'h0000_1000, 32'h5555_AAAA);
    rd(PB + 32'h14);
    wr(32'h5, 32'hCAFE_F00D);
    rd(PB + 32'h14);
    rd(32'h4);
    wr(PB + 32'h14, 32'd3);
    rd(32'h0000_2000);
    rd(32'h8000_0001);
    rd(PB + 32'h14);

    // LED and reserved offset.
    wr(PB + 32'h10, 32'h1234_56A5);
    rd(PB + 32'h10);
    wr(PB + 32'h20, 32'hFFFF_FFFF);
    rd(PB + 32'h20);

    // Asynchronous reset mid-run; a store during reset is dropped.
    wr(PB + 32'h8, 32'd5);
    wr(PB + 32'h10, 32'hFF);
    wr(32'h0000_4000, 32'h1);
    rd(PB);
    step(1'b1, 32'h10, 32'h0BAD_0BAD, 1'b0);
    step(1'b1, 32'h10, 32'h0BAD_0BAD, 1'b0);
    rd(32'h10);
    rd(PB);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      r  = $urandom_range(0, 9);
      we = ($urandom_range(0, 3) == 0);
      wd = $urandom;
      if (r < 4) begin
        a = 32'($urandom_range(0, RAM_WORDS - 1)) * 4;
        if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      end else if (r < 8) begin
        a = PB + 32'($urandom_range(0, 15)) * 4;
        if (a == PB || a == PB + 32'h4) wd = 32'($urandom_range(0, 12));
      end else begin
        a = $urandom;
      end
      rl = ($urandom_range(0, 199) != 0);
      step(we, a, wd, rl);
    end
    step(1'b0, PB, 32'h0, 1'b1);

    repeat (4) @(posedge clk);
    checks++;
    if (scb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain addr=0 got=%0d expected=0", scb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_dmem_responder.md
# mips_dmem_responder

Data-side memory responder for the pipelined MIPS core: the target end of the core's MEM-stage data interface (`memwrite`, `memaddr`, `memwritedata`, `memreaddata`). It answers loads combinationally within the same cycle and commits stores on the clock edge. It also decodes a small peripheral window holding a free-running timer with compare and interrupt, an LED register and a sticky bus-error status. It sits beside the core at the system level, replacing a bare data RAM.

## Interface

Parameters:
- `RAM_WORDS`, 64: data RAM depth in 32-bit words; must be a power of two, ≥ 4.
- `PERIPH_BASE`, 32'hFFFF0000: byte base of the peripheral window, 64-byte aligned.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `memwrite`  in  1  store strobe from the core's MEM stage.
- `memaddr`  in  32  byte address from the MEM stage.
- `memwritedata`  in  32  store data.
- `memreaddata`  out  32  load data; combinational from `memaddr`.
- `leds`  out  8  LED register contents.
- `timer_irq`  out  1  `STAT.match & CTRL.irqen`.
- `bus_err`  out  1  OR of the ERR status bits.

## Operation

- Decode is on the word address `memaddr[31:2]`.
- RAM hit: `memaddr < RAM_WORDS*4`.
- Peripheral hit: `memaddr[31:6] == PERIPH_BASE[31:6]`.
- Anything else is unmapped.
- Peripheral offsets:
  - +0x00 CNT (RW, 32): timer counter.
  - +0x04 CMP (RW, 32): compare value.
  - +0x08 CTRL (RW, bits [2:0]): bit0 = en, bit1 = autoclr, bit2 = irqen; reads return zeros above bit 2.
  - +0x0C STAT (bit0 = match): write-1-to-clear.
  - +0x10 LED (RW, bits [7:0]).
  - +0x14 ERR: bit0 = unmapped store, bit1 = misaligned store; sticky, write-1-to-clear.
  - Other offsets inside the window read 0; stores there are ignored without error.
- Reads:
  - Any access with `memaddr[1:0]` ≠ 0 ignores those bits.
  - Unmapped reads return 32'h0 and do not set ERR; reads have no strobe and no side effects.
- Stores, with `memwrite` = 1 at a rising edge:
  - Misaligned (`memaddr[1:0]` ≠ 0): no state is written and ERR.bit1 is set.
  - Unmapped and aligned: ERR.bit0 is set.
  - Otherwise the full 32-bit target is written. There are no byte enables.
- Timer, each edge:
  - CPU store to CNT: CNT ← `memwritedata`. This has priority over increment and auto-clear.
  - Else if en and `CNT == CMP` and autoclr: CNT ← 0.
  - Else if en: CNT ← CNT + 1, wrapping modulo 2^32.
  - STAT.match is set on any edge where en and `CNT == CMP`, comparing pre-edge values.
  - If a set and a W1C of STAT land on the same edge, set wins.
- ERR: a new error and a W1C of the same bit on the same edge leaves the bit set.
- Reset (asserted):
  - CNT = 0, CMP = 32'hFFFFFFFF, CTRL = 0, STAT = 0, LED = 0, ERR = 0.
  - Outputs: `leds` = 0, `timer_irq` = 0, `bus_err` = 0.
  - `memreaddata` follows decode; a RAM address reads whatever the array holds.
  - RAM contents are not reset.
- Reset asserted mid-operation clears registers immediately, with no wait for `clk`. A store presented on the edge where reset releases is not taken if reset is still low at that edge.

## Timing

- Load latency: zero cycles. `memreaddata` is valid combinationally in the same cycle as `memaddr`, and the core samples it at the next edge.
- Store latency: committed at the rising edge where `memwrite` = 1; visible to reads from the following cycle.
- A read of an address being stored in the same cycle returns the old value (no write-through).
- CNT read returns the pre-edge value; with en = 1, consecutive-cycle reads differ by 1.
- Match-to-IRQ latency: `CNT == CMP` in cycle N gives STAT.match = 1 and `timer_irq` (if irqen) from cycle N+1.
- Auto-clear: with CMP = K, en = 1, autoclr = 1, CNT sequences 0..K, 0..K, giving a period of K+1 cycles.
- Critical path: address decode plus the RAM read mux into `memreaddata`. No other combinational path reaches an output.

## Test plan

- Reset and RAM: assert `reset` low, then release; check `leds` = 0, `timer_irq` = 0, `bus_err` = 0. Store 32'hDEADBEEF to 0x10 → reading 0x10 the next cycle returns 32'hDEADBEEF; reading 0x10 in the same cycle as the store returns the prior value.
- Timer with auto-clear:
  - Write CMP = 3, then CTRL = 3'b111 → CNT reads 0,1,2,3,0,1.
  - STAT.match = 1 and `timer_irq` = 1 one cycle after CNT = 3.
  - W1C STAT → `timer_irq` = 0 next cycle, unless that edge is another match.
- Priority: with en = 1 and CNT == CMP, store CNT = 100 on that edge → CNT reads 100, then 101. STAT.match is still set.
- Bus errors:
  - Store to 0x0000_1000 (with RAM_WORDS = 64) → `bus_err` = 1, ERR reads 1, RAM is unchanged.
  - Store to 0x5 → ERR reads 3 and word 0x4 is unchanged.
  - W1C 3 to ERR → `bus_err` = 0.
  - Loads from unmapped addresses return 0 and never set ERR.
- LED and reserved offsets: store 32'h1234_56A5 to LED → `leds` = 8'hA5, and LED reads 32'h0000_00A5. A store to +0x20 reads back 0 and leaves `bus_err` = 0.
- Async reset mid-run: with timer counting, `leds` = 8'hFF and ERR set, pull `reset` low between edges → all registers and outputs clear before the next edge. RAM word 0x10 still reads 32'hDEADBEEF.
